alu_control_fsm: RTL and testbench

- Multi-cycle control sequencer that drives the 8-bit ALU from the instruction side.
- Accepts a 32-bit instruction word over a valid/ready handshake, decodes it, and sequences register-file reads, ALU operation select, writeback and branch resolution.
- Consumes the ALU ZERO flag for beq.
- Sits between the instruction fetch path and the datapath (register file, immediate/negate muxes, ALU, PC logic).

---
 rtl/alu_control_fsm.sv | 173 +++++++++++++++++
 tb/tb_alu_control_fsm.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_control_fsm.sv
// rtl/alu_control_fsm.sv - multi-cycle instruction sequencer driving the 8-bit ALU datapath
module alu_control_fsm #(
  parameter int EXEC_CYCLES = 1,
  parameter int REG_ADDR_W  = 3
) (
  input  logic                  CLK,
  input  logic                  RESET,
  input  logic [31:0]           INSTR,
  input  logic                  INSTR_VALID,
  output logic                  INSTR_READY,
  input  logic                  ZERO,
  output logic [REG_ADDR_W-1:0] READREG1,
  output logic [REG_ADDR_W-1:0] READREG2,
  output logic [REG_ADDR_W-1:0] WRITEREG,
  output logic [7:0]            IMMEDIATE,
  output logic [2:0]            ALUOP,
  output logic                  IMM_SEL,
  output logic                  NEG_SEL,
  output logic                  WRITEENABLE,
  output logic                  PC_UPDATE,
  output logic                  BRANCH_TAKEN,
  output logic [7:0]            OFFSET,
  output logic                  ILLEGAL
);

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_WB     = 3'd3,
    S_RETIRE = 3'd4
  } state_t;

  localparam logic [3:0] EXEC_LAST = 4'(EXEC_CYCLES - 1);

  state_t      state;
  state_t      state_nxt;
  logic [31:0] ir;
  logic [3:0]  exec_cnt;

  // Decoded opcode fields, captured at the end of DECODE
  logic [2:0]  aluop_q;
  logic        imm_sel_q;
  logic        neg_sel_q;
  logic        writes_q;
  logic        jump_q;
  logic        beq_q;
  logic        zero_q;

  // Combinational opcode decode of the held instruction
  logic [2:0]  dec_aluop;
  logic        dec_imm_sel;
  logic        dec_neg_sel;
  logic        dec_writes;
  logic        dec_jump;
  logic        dec_beq;
  logic        dec_legal;

  // Upper bits of the SRC1 byte are dropped by address truncation
  logic        unused_src1_hi;
  assign unused_src1_hi = ^ir[15:8];

  // Operand fields come straight from IR, so they hold for the whole instruction
  assign READREG1  = ir[8  +: REG_ADDR_W];
  assign READREG2  = ir[0  +: REG_ADDR_W];
  assign WRITEREG  = ir[16 +: REG_ADDR_W];
  assign IMMEDIATE = ir[7:0];
  assign OFFSET    = ir[23:16];
  assign ALUOP     = aluop_q;
  assign IMM_SEL   = imm_sel_q;
  assign NEG_SEL   = neg_sel_q;

  // Opcode table: ALU select, operand muxing and retire kind
  always_comb begin
    dec_aluop   = 3'b000;
    dec_imm_sel = 1'b0;
    dec_neg_sel = 1'b0;
    dec_writes  = 1'b0;
    dec_jump    = 1'b0;
    dec_beq     = 1'b0;
    dec_legal   = 1'b1;
    case (ir[31:24])
      8'h00: begin dec_imm_sel = 1'b1; dec_writes = 1'b1; end
      8'h01: dec_writes = 1'b1;
      8'h02: begin dec_aluop = 3'b001; dec_writes = 1'b1; end
      8'h03: begin dec_aluop = 3'b001; dec_neg_sel = 1'b1; dec_writes = 1'b1; end
      8'h04: begin dec_aluop = 3'b010; dec_writes = 1'b1; end
      8'h05: begin dec_aluop = 3'b011; dec_writes = 1'b1; end
      8'h06: dec_jump = 1'b1;
      8'h07: begin dec_aluop = 3'b001; dec_neg_sel = 1'b1; dec_beq = 1'b1; end
      default: dec_legal = 1'b0;
    endcase
  end

  // State register
  always_ff @(posedge CLK) begin
    if (!RESET) begin
      state <= S_FETCH;
    end else begin
      state <= state_nxt;
    end
  end

  // Instruction register, decode capture, EXEC hold counter and ZERO sample
  always_ff @(posedge CLK) begin
    if (!RESET) begin
      ir        <= 32'h0;
      exec_cnt  <= 4'd0;
      aluop_q   <= 3'b000;
      imm_sel_q <= 1'b0;
      neg_sel_q <= 1'b0;
      writes_q  <= 1'b0;
      jump_q    <= 1'b0;
      beq_q     <= 1'b0;
      zero_q    <= 1'b0;
    end else begin
      if (state == S_FETCH && INSTR_VALID) begin
        ir <= INSTR;
      end
      if (state == S_DECODE) begin
        aluop_q   <= dec_aluop;
        imm_sel_q <= dec_imm_sel;
        neg_sel_q <= dec_neg_sel;
        writes_q  <= dec_writes;
        jump_q    <= dec_jump;
        beq_q     <= dec_beq;
      end
      if (state == S_EXEC) begin
        if (exec_cnt == EXEC_LAST) begin
          exec_cnt <= 4'd0;
          zero_q   <= ZERO;
        end else begin
          exec_cnt <= exec_cnt + 4'd1;
        end
      end
    end
  end

  // Next-state and strobe outputs; strobes are forced low while reset is held
  always_comb begin
    state_nxt    = state;
    INSTR_READY  = 1'b0;
    WRITEENABLE  = 1'b0;
    PC_UPDATE    = 1'b0;
    BRANCH_TAKEN = 1'b0;
    ILLEGAL      = 1'b0;
    case (state)
      S_FETCH: begin
        INSTR_READY = RESET;
        if (INSTR_VALID) state_nxt = S_DECODE;
      end
      S_DECODE: begin
        ILLEGAL   = RESET & ~dec_legal;
        state_nxt = dec_legal ? S_EXEC : S_RETIRE;
      end
      S_EXEC: begin
        if (exec_cnt == EXEC_LAST) state_nxt = writes_q ? S_WB : S_RETIRE;
      end
      S_WB: begin
        WRITEENABLE = RESET;
        PC_UPDATE   = RESET;
        state_nxt   = S_FETCH;
      end
      S_RETIRE: begin
        PC_UPDATE    = RESET;
        BRANCH_TAKEN = RESET & (jump_q | (beq_q & zero_q));
        state_nxt    = S_FETCH;
      end
      default: state_nxt = S_FETCH;
    endcase
  end

endmodule

// File: tb/tb_alu_control_fsm.sv
// tb/tb_alu_control_fsm.sv - scoreboard bench for alu_control_fsm
module tb_alu_control_fsm;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  // Instance with EXEC_CYCLES=1
  logic        rst_n, instr_valid, zero;
  logic [31:0] instr;
  logic        instr_ready, imm_sel, neg_sel, writeenable, pc_update, branch_taken, illegal;
  logic [2:0]  readreg1, readreg2, writereg, aluop;
  logic [7:0]  immediate, offset;

  alu_control_fsm #(.EXEC_CYCLES(1), .REG_ADDR_W(3)) dut (
    .CLK(clk), .RESET(rst_n), .INSTR(instr), .INSTR_VALID(instr_valid),
    .INSTR_READY(instr_ready), .ZERO(zero), .READREG1(readreg1), .READREG2(readreg2),
    .WRITEREG(writereg), .IMMEDIATE(immediate), .ALUOP(aluop), .IMM_SEL(imm_sel),
    .NEG_SEL(neg_sel), .WRITEENABLE(writeenable), .PC_UPDATE(pc_update),
    .BRANCH_TAKEN(branch_taken), .OFFSET(offset), .ILLEGAL(illegal)
  );

  // Instance with EXEC_CYCLES=4
  logic        rst4_n, valid4, zero4;
  logic [31:0] instr4;
  logic        ready4, imm_sel4, neg_sel4, we4, pc4, bt4, ill4;
  logic [2:0]  rr1_4, rr2_4, wr_4, aluop4;
  logic [7:0]  imm4, off4;

  alu_control_fsm #(.EXEC_CYCLES(4), .REG_ADDR_W(3)) dut4 (
    .CLK(clk), .RESET(rst4_n), .INSTR(instr4), .INSTR_VALID(valid4),
    .INSTR_READY(ready4), .ZERO(zero4), .READREG1(rr1_4), .READREG2(rr2_4),
    .WRITEREG(wr_4), .IMMEDIATE(imm4), .ALUOP(aluop4), .IMM_SEL(imm_sel4),
    .NEG_SEL(neg_sel4), .WRITEENABLE(we4), .PC_UPDATE(pc4),
    .BRANCH_TAKEN(bt4), .OFFSET(off4), .ILLEGAL(ill4)
  );

  typedef struct {
    logic       we, bt, ill;
    int         lat;
    logic [2:0] aluop;
    logic       imm_sel, neg_sel;
    logic [2:0] rr1, rr2, wr;
    logic [7:0] imm, off;
  } exp_t;

  exp_t sbq[$];
  exp_t e;
  int   n_cmp = 0;
  int   n_bad = 0;

  task automatic chk(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s[%0d]: actual=0x%0h required=0x%0h", name, idx, act, exp);
    end
  endtask

  function automatic exp_t mk(input logic we, input logic bt, input logic ill, input int lat,
                              input logic [2:0] aop, input logic isel, input logic nsel,
                              input logic [2:0] r1, input logic [2:0] r2, input logic [2:0] w,
                              input logic [7:0] im, input logic [7:0] of);
    exp_t x;
    x.we = we; x.bt = bt; x.ill = ill; x.lat = lat;
    x.aluop = aop; x.imm_sel = isel; x.neg_sel = nsel;
    x.rr1 = r1; x.rr2 = r2; x.wr = w; x.imm = im; x.off = of;
    return x;
  endfunction

  // Monitor: tracks each accepted instruction and checks it against the queue head at retire
  bit         busy = 0, ready_chk = 0;
  int         acc_cyc = 0, we_cnt = 0, ill_cnt = 0, rr1_bad = 0, retired = 0;
  logic [2:0] s_aluop;
  logic       s_imm, s_neg;

  always @(negedge clk) begin
    if (rst_n !== 1'b1) begin
      busy = 0;
      ready_chk = 0;
    end else begin
      if (ready_chk) begin
        chk("ready_after_retire", retired, 32'(instr_ready), 32'd1);
        ready_chk = 0;
      end
      if (busy) begin
        if (sbq.size() > 0 && readreg1 !== sbq[0].rr1) rr1_bad++;
        if (cyc == acc_cyc + 1) begin
          s_aluop = aluop; s_imm = imm_sel; s_neg = neg_sel;
        end
        if (writeenable === 1'b1) we_cnt++;
        if (illegal === 1'b1) ill_cnt++;
        if (pc_update === 1'b1) begin
          if (sbq.size() == 0) begin
            n_cmp++; n_bad++;
            $display("FAIL sb_underflow[%0d]: actual=retire required=empty", retired);
          end else begin
            e = sbq.pop_front();
            chk("latency", retired, 32'(cyc - acc_cyc + 1), 32'(e.lat));
            chk("we_pulses", retired, 32'(we_cnt), 32'(e.we));
            chk("illegal_pulses", retired, 32'(ill_cnt), 32'(e.ill));
            chk("branch_taken", retired, 32'(branch_taken), 32'(e.bt));
            chk("rr1_stable", retired, 32'(rr1_bad), 32'd0);
            chk("readreg2", retired, 32'(readreg2), 32'(e.rr2));
            chk("writereg", retired, 32'(writereg), 32'(e.wr));
            chk("immediate", retired, 32'(immediate), 32'(e.imm));
            chk("offset", retired, 32'(offset), 32'(e.off));
            if (!e.ill) begin
              chk("aluop", retired, 32'(s_aluop), 32'(e.aluop));
              chk("imm_sel", retired, 32'(s_imm), 32'(e.imm_sel));
              chk("neg_sel", retired, 32'(s_neg), 32'(e.neg_sel));
            end
          end
          busy = 0;
          ready_chk = 1;
          retired++;
        end else if (cyc - acc_cyc > 30) begin
          n_cmp++; n_bad++;
          $display("FAIL retire_timeout[%0d]: actual=no PC_UPDATE required=retire", retired);
          busy = 0;
        end
      end
      if (!busy && instr_ready === 1'b1 && instr_valid === 1'b1) begin
        busy = 1; acc_cyc = cyc + 1; we_cnt = 0; ill_cnt = 0; rr1_bad = 0;
      end
    end
  end

  // Issue one instruction to the EXEC_CYCLES=1 instance; optionally wiggle INSTR/INSTR_VALID while busy
  task automatic send(input logic [31:0] i, input logic z, input exp_t x, input bit toggle);
    int n;
    n = 0;
    while (instr_ready !== 1'b1) begin
      @(posedge clk); #1;
      n++;
      if (n > 40) begin
        n_cmp++; n_bad++;
        $display("FAIL ready_timeout: actual=0 required=1");
        return;
      end
    end
    sbq.push_back(x);
    instr = i; zero = z; instr_valid = 1'b1;
    @(posedge clk); #1;
    instr_valid = 1'b0;
    if (toggle) begin
      instr = 32'h02000700; instr_valid = 1'b1;
      @(posedge clk); #1;
      instr = 32'h05FF06FF; instr_valid = 1'b1;
      @(posedge clk); #1;
      instr_valid = 1'b0;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: actual=running required=finished");
    $fatal(1, "watchdog");
  end

  int lat, bad_aop, seen;

  initial begin
    rst_n = 1'b0; rst4_n = 1'b0;
    instr = 32'h0004002A; instr_valid = 1'b1; zero = 1'b0;
    instr4 = 32'h0; valid4 = 1'b0; zero4 = 1'b0;

    for (int k = 0; k < 2; k++) begin
      @(posedge clk); #1;
      chk("rst_ready", k, 32'(instr_ready), 32'd0);
      chk("rst_we", k, 32'(writeenable), 32'd0);
      chk("rst_pc", k, 32'(pc_update), 32'd0);
      chk("rst_bt", k, 32'(branch_taken), 32'd0);
      chk("rst_ill", k, 32'(illegal), 32'd0);
      chk("rst_aluop", k, 32'(aluop), 32'd0);
      chk("rst_sels", k, 32'({imm_sel, neg_sel}), 32'd0);
      chk("rst_regs", k, 32'({readreg1, readreg2, writereg}), 32'd0);
      chk("rst_imm_off", k, 32'({immediate, offset}), 32'd0);
    end
    instr_valid = 1'b0;
    rst_n = 1'b1; rst4_n = 1'b1;
    @(posedge clk); #1;
    chk("release_ready", 0, 32'(instr_ready), 32'd1);
    chk("release_no_accept", 0, 32'(busy), 32'd0);

    send(32'h0004002A, 1'b0, mk(1, 0, 0, 3, 3'b000, 1, 0, 3'd0, 3'd2, 3'd4, 8'h2A, 8'h04), 0);
    send(32'h03020103, 1'b0, mk(1, 0, 0, 3, 3'b001, 0, 1, 3'd1, 3'd3, 3'd2, 8'h03, 8'h02), 0);
    send(32'h07FC0102, 1'b1, mk(0, 1, 0, 3, 3'b001, 0, 1, 3'd1, 3'd2, 3'd4, 8'h02, 8'hFC), 0);
    send(32'h07FC0102, 1'b0, mk(0, 0, 0, 3, 3'b001, 0, 1, 3'd1, 3'd2, 3'd4, 8'h02, 8'hFC), 0);
    send(32'h09000000, 1'b0, mk(0, 0, 1, 2, 3'b000, 0, 0, 3'd0, 3'd0, 3'd0, 8'h00, 8'h00), 0);
    send(32'h06050000, 1'b0, mk(0, 1, 0, 3, 3'b000, 0, 0, 3'd0, 3'd0, 3'd5, 8'h00, 8'h05), 0);
    send(32'h02030102, 1'b1, mk(1, 0, 0, 3, 3'b001, 0, 0, 3'd1, 3'd2, 3'd3, 8'h02, 8'h03), 0);
    send(32'h04010B0C, 1'b0, mk(1, 0, 0, 3, 3'b010, 0, 0, 3'd3, 3'd4, 3'd1, 8'h0C, 8'h01), 0);
    send(32'h05070605, 1'b0, mk(1, 0, 0, 3, 3'b011, 0, 0, 3'd6, 3'd5, 3'd7, 8'h05, 8'h07), 0);
    send(32'h01060500, 1'b0, mk(1, 0, 0, 3, 3'b000, 0, 0, 3'd5, 3'd0, 3'd6, 8'h00, 8'h06), 1);
    send(32'hFF123456, 1'b0, mk(0, 0, 1, 2, 3'b000, 0, 0, 3'd4, 3'd6, 3'd2, 8'h56, 8'h12), 0);

    for (int k = 0; k < 100 && (sbq.size() != 0 || busy); k++) begin
      @(posedge clk); #1;
    end
    chk("sb_drain", 0, 32'(sbq.size()), 32'd0);

    // EXEC_CYCLES=4: full add, latency 1+4+1, ALUOP held through every EXEC cycle
    instr4 = 32'h02030102; valid4 = 1'b1;
    @(posedge clk); #1;
    valid4 = 1'b0;
    lat = 1; bad_aop = 0;
    while (pc4 !== 1'b1 && lat < 20) begin
      @(posedge clk); #1;
      lat++;
      if (lat >= 2 && lat <= 5 && aluop4 !== 3'b001) bad_aop++;
    end
    chk("ec4_latency", 0, 32'(lat), 32'd6);
    chk("ec4_we", 0, 32'(we4), 32'd1);
    chk("ec4_bt", 0, 32'(bt4), 32'd0);
    chk("ec4_aluop_hold", 0, 32'(bad_aop), 32'd0);
    @(posedge clk); #1;
    chk("ec4_ready_after", 0, 32'(ready4), 32'd1);

    // EXEC_CYCLES=4: reset on the 2nd EXEC cycle aborts the add
    instr4 = 32'h02030102; valid4 = 1'b1;
    @(posedge clk); #1;
    valid4 = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("midrst_exec_aluop", 0, 32'(aluop4), 32'd1);
    rst4_n = 1'b0;
    @(posedge clk); #1;
    chk("midrst_ready_in_rst", 0, 32'(ready4), 32'd0);
    rst4_n = 1'b1;
    seen = 0;
    for (int k = 0; k < 10; k++) begin
      if (we4 === 1'b1 || pc4 === 1'b1) seen++;
      @(posedge clk); #1;
    end
    chk("midrst_no_strobes", 0, 32'(seen), 32'd0);
    chk("midrst_back_fetch", 0, 32'(ready4), 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
